// File: rtl/tone_gen.sv
// Piano tone generator: picks the highest-numbered pressed key and drives a 50%-duty
// square wave at its pitch, changing pitch or stopping only at half-period boundaries.
module tone_gen #(
    parameter bit SIM = 1'b0,
    parameter int HW  = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] KEYS,
    input  logic       ENABLE,
    output logic       SPK,
    output logic       ACTIVE,
    output logic [2:0] NOTE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        STOP = 2'd2
    } state_t;

    // Half-period length in CLK cycles for each key (C4..C5 at 100 MHz).
    function automatic logic [HW-1:0] half_tbl(input logic [2:0] k);
        logic [HW-1:0] h;
        if (SIM) begin
            h = HW'(5'd4) + HW'({k, 1'b0});
        end else begin
            case (k)
                3'd0:    h = HW'(18'd191113);
                3'd1:    h = HW'(18'd170262);
                3'd2:    h = HW'(18'd151686);
                3'd3:    h = HW'(18'd143173);
                3'd4:    h = HW'(18'd127551);
                3'd5:    h = HW'(18'd113636);
                3'd6:    h = HW'(18'd101239);
                3'd7:    h = HW'(18'd95556);
                default: h = HW'(18'd191113);
            endcase
        end
        return h;
    endfunction

    function automatic logic [2:0] prio_sel(input logic [7:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                s = 3'(i);
            end
        end
        return s;
    endfunction

    state_t        state_q;
    logic [7:0]    key_q;
    logic [7:0]    key_d;
    logic [2:0]    sel;
    logic          term;
    logic [HW-1:0] cnt_q;
    logic [HW-1:0] cnt_d;
    logic [HW-1:0] half_q;
    logic          spk_q;
    logic          active_q;
    logic [2:0]    note_q;

    assign key_d = ENABLE ? KEYS : 8'h00;
    assign sel   = prio_sel(key_q);
    // Terminal count of the half in progress; cnt never goes past it.
    assign term  = (cnt_q == (half_q - HW'(1'b1)));
    assign cnt_d = cnt_q + HW'(1'b1);

    assign SPK    = spk_q;
    assign ACTIVE = active_q;
    assign NOTE   = note_q;

    // Key register, note sequencer and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            key_q    <= 8'h00;
            cnt_q    <= {HW{1'b0}};
            half_q   <= half_tbl(3'd0);
            spk_q    <= 1'b0;
            active_q <= 1'b0;
            note_q   <= 3'd0;
        end else begin
            key_q <= key_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= {HW{1'b0}};
                    if (key_q != 8'h00) begin
                        state_q  <= PLAY;
                        active_q <= 1'b1;
                        note_q   <= sel;
                        half_q   <= half_tbl(sel);
                        spk_q    <= 1'b1;
                    end else begin
                        spk_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (key_q != 8'h00) begin
                        if (term) begin
                            spk_q  <= ~spk_q;
                            cnt_q  <= {HW{1'b0}};
                            note_q <= sel;
                            half_q <= half_tbl(sel);
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else if (!spk_q) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        cnt_q    <= {HW{1'b0}};
                    end else if (term) begin
                        // Released on the last cycle of a high half: nothing left to finish.
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        spk_q    <= 1'b0;
                        cnt_q    <= {HW{1'b0}};
                    end else begin
                        state_q <= STOP;
                        cnt_q   <= cnt_d;
                    end
                end
                STOP: begin
                    if (term) begin
                        spk_q <= 1'b0;
                        cnt_q <= {HW{1'b0}};
                        if (key_q != 8'h00) begin
                            state_q <= PLAY;
                            note_q  <= sel;
                            half_q  <= half_tbl(sel);
                        end else begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                    spk_q    <= 1'b0;
                    cnt_q    <= {HW{1'b0}};
                end
            endcase
        end
    end

endmodule
